// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter: inhibit, request-to-send, 11-edge frame, ACK check.
// Define PS2_TX_RETRY_EN to retry a failed transfer up to two times before reporting err.
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 10000,
    parameter int RTS_CYCLES     = 2000,
    parameter int FILTER_CYCLES  = 16,
    parameter int TIMEOUT_CYCLES = 2000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_ready,
    input  logic       kclk,
    input  logic       kdata,
    output logic       kclk_oe,
    output logic       kdata_oe,
    output logic       busy,
    output logic       done,
    output logic       err
);

    localparam int CW = 32;
    localparam int FW = $clog2(FILTER_CYCLES + 1);
    localparam logic [CW-1:0] INH_LAST  = CW'(INHIBIT_CYCLES - 1);
    localparam logic [CW-1:0] RTS_LAST  = CW'(RTS_CYCLES - 1);
    localparam logic [CW-1:0] TO_LAST   = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [FW-1:0] FILT_LAST = FW'(FILTER_CYCLES - 1);

    typedef enum logic [2:0] {S_IDLE, S_INHIBIT, S_RTS, S_SEND, S_WAIT_REL} state_t;

    logic          kclk_m_q, kclk_s_q, kdata_m_q, kdata_s_q;
    logic          kclk_f_q, kclk_f_d;
    logic [FW-1:0] filt_q, filt_d;
    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    edge_q, edge_d, edge_nxt;
    logic [7:0]    byte_q, byte_d;
    logic          par_q, par_d;
    logic          kclk_oe_q, kclk_oe_d, kdata_oe_q, kdata_oe_d;
    logic          busy_q, busy_d, ready_q, ready_d;
    logic          done_q, done_d, err_q, err_d;
    logic          kclk_fall, fail;
`ifdef PS2_TX_RETRY_EN
    logic [1:0]    retry_q, retry_d;
`endif

    always_comb begin
        kclk_f_d   = kclk_f_q;
        filt_d     = filt_q;
        kclk_fall  = 1'b0;
        state_d    = state_q;
        cnt_d      = cnt_q;
        edge_d     = edge_q;
        edge_nxt   = edge_q + 4'd1;
        byte_d     = byte_q;
        par_d      = par_q;
        kclk_oe_d  = kclk_oe_q;
        kdata_oe_d = kdata_oe_q;
        done_d     = 1'b0;
        err_d      = 1'b0;
        fail       = 1'b0;
`ifdef PS2_TX_RETRY_EN
        retry_d    = retry_q;
`endif

        // A level change is accepted only after FILTER_CYCLES consecutive differing samples.
        if (kclk_s_q == kclk_f_q) begin
            filt_d = '0;
        end else if (filt_q == FILT_LAST) begin
            filt_d    = '0;
            kclk_f_d  = kclk_s_q;
            kclk_fall = kclk_f_q;
        end else begin
            filt_d = filt_q + 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (tx_valid) begin
                    byte_d     = tx_data;
                    par_d      = ~^tx_data;
                    edge_d     = '0;
                    cnt_d      = '0;
                    kclk_oe_d  = 1'b1;
                    kdata_oe_d = 1'b0;
                    state_d    = S_INHIBIT;
`ifdef PS2_TX_RETRY_EN
                    retry_d    = '0;
`endif
                end
            end
            S_INHIBIT: begin
                if (cnt_q == INH_LAST) begin
                    cnt_d      = '0;
                    kdata_oe_d = 1'b1;
                    state_d    = S_RTS;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_RTS: begin
                if (cnt_q == RTS_LAST) begin
                    cnt_d     = '0;
                    edge_d    = '0;
                    kclk_oe_d = 1'b0;
                    state_d   = S_SEND;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_SEND: begin
                if (kclk_fall) begin
                    cnt_d  = '0;
                    edge_d = edge_nxt;
                    case (edge_nxt)
                        4'd1, 4'd2, 4'd3, 4'd4,
                        4'd5, 4'd6, 4'd7, 4'd8: kdata_oe_d = ~byte_q[edge_q[2:0]];
                        4'd9:                   kdata_oe_d = ~par_q;
                        4'd10:                  kdata_oe_d = 1'b0;
                        default: begin
                            if (kdata_s_q) fail = 1'b1;
                            else           state_d = S_WAIT_REL;
                        end
                    endcase
                end else if (cnt_q == TO_LAST) begin
                    fail = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_WAIT_REL: begin
                if (kclk_s_q && kdata_s_q) begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end else if (cnt_q == TO_LAST) begin
                    fail = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

`ifdef PS2_TX_RETRY_EN
        if (fail && retry_q != 2'd2) begin
            retry_d    = retry_q + 2'd1;
            cnt_d      = '0;
            edge_d     = '0;
            kclk_oe_d  = 1'b1;
            kdata_oe_d = 1'b0;
            state_d    = S_INHIBIT;
        end else
`endif
        if (fail) begin
            cnt_d      = '0;
            kclk_oe_d  = 1'b0;
            kdata_oe_d = 1'b0;
            err_d      = 1'b1;
            state_d    = S_IDLE;
        end

        busy_d  = (state_d != S_IDLE);
        ready_d = (state_d == S_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            kclk_m_q   <= 1'b1;
            kclk_s_q   <= 1'b1;
            kdata_m_q  <= 1'b1;
            kdata_s_q  <= 1'b1;
            kclk_f_q   <= 1'b1;
            filt_q     <= '0;
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            edge_q     <= '0;
            byte_q     <= '0;
            par_q      <= 1'b0;
            kclk_oe_q  <= 1'b0;
            kdata_oe_q <= 1'b0;
            busy_q     <= 1'b0;
            ready_q    <= 1'b1;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
`ifdef PS2_TX_RETRY_EN
            retry_q    <= '0;
`endif
        end else begin
            kclk_m_q   <= kclk;
            kclk_s_q   <= kclk_m_q;
            kdata_m_q  <= kdata;
            kdata_s_q  <= kdata_m_q;
            kclk_f_q   <= kclk_f_d;
            filt_q     <= filt_d;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            edge_q     <= edge_d;
            byte_q     <= byte_d;
            par_q      <= par_d;
            kclk_oe_q  <= kclk_oe_d;
            kdata_oe_q <= kdata_oe_d;
            busy_q     <= busy_d;
            ready_q    <= ready_d;
            done_q     <= done_d;
            err_q      <= err_d;
`ifdef PS2_TX_RETRY_EN
            retry_q    <= retry_d;
`endif
        end
    end

    assign kclk_oe  = kclk_oe_q;
    assign kdata_oe = kdata_oe_q;
    assign busy     = busy_q;
    assign tx_ready = ready_q;
    assign done     = done_q;
    assign err      = err_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: open-drain line model plus a PS/2 device model that clocks frames,
// reads the host's bits on each rising edge, and ACKs, NACKs or stalls on request.
module tb_ps2_host_tx;

    localparam int INH  = 20;
    localparam int RTSC = 10;
    localparam int FILT = 4;
    localparam int TO   = 400;
    localparam int HALF = 20;
`ifdef PS2_TX_RETRY_EN
    localparam int NFR = 3;
`else
    localparam int NFR = 1;
`endif

    logic       clk = 1'b0, rst = 1'b1, tx_valid = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       dev_clk_low = 1'b0, dev_data_low = 1'b0;
    logic       kclk_line, kdata_line;
    logic       kclk_oe, kdata_oe, tx_ready, busy, done, err;

    assign kclk_line  = ~(dev_clk_low | kclk_oe);
    assign kdata_line = ~(dev_data_low | kdata_oe);

    ps2_host_tx #(.INHIBIT_CYCLES(INH), .RTS_CYCLES(RTSC), .FILTER_CYCLES(FILT),
                  .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst), .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
        .kclk(kclk_line), .kdata(kdata_line), .kclk_oe(kclk_oe), .kdata_oe(kdata_oe),
        .busy(busy), .done(done), .err(err));

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int done_cnt = 0, err_cnt = 0, err_cyc = 0;
    always @(negedge clk) begin
        if (done) done_cnt++;
        if (err) begin err_cnt++; err_cyc = cyc; end
    end

    int n_tests = 0, n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic bound_fail(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: wait bound expired", name);
    endtask

    // Reference frame as read by the device: data LSB-first, odd parity, released stop bit.
    function automatic logic [9:0] frame_model(input logic [7:0] d);
        int ones;
        ones = $countones(d);
        return {1'b1, (ones % 2 == 0) ? 1'b1 : 1'b0, d};
    endfunction

    task automatic start_tx(input logic [7:0] d);
        @(negedge clk);
        chk("tx_ready_before_start", {31'd0, tx_ready}, 32'd1);
        tx_valid = 1'b1;
        tx_data  = d;
        @(negedge clk);
        tx_valid = 1'b0;
        tx_data  = 8'($urandom);
    endtask

    task automatic dev_frame(input bit nack, input int stop_after, input bit chk_t,
                             output logic [9:0] bits, output int t4, output bit ok);
        int inh, rts, n;
        inh = 0; rts = 0; n = 0; bits = '0; t4 = 0; ok = 1'b0;
        while (kclk_oe !== 1'b1) begin
            n++;
            if (n > 3 * TO) begin bound_fail("inhibit_wait"); return; end
            @(negedge clk);
        end
        n = 0;
        while (!(kclk_oe === 1'b0 && kdata_oe === 1'b1)) begin
            if (kclk_oe && !kdata_oe) inh++;
            if (kclk_oe && kdata_oe)  rts++;
            n++;
            if (n > 3 * TO) begin bound_fail("send_wait"); return; end
            @(negedge clk);
        end
        if (chk_t) begin
            chk("inhibit_cycles", inh, INH);
            chk("rts_cycles", rts, RTSC);
        end
        chk("start_bit_low", {31'd0, kdata_line}, 32'd0);
        for (int e = 1; e <= 11; e++) begin
            if (stop_after != 0 && e > stop_after) break;
            if (e == 11 && !nack) dev_data_low = 1'b1;
            repeat (HALF) @(negedge clk);
            dev_clk_low = 1'b1;
            if (e == 4) t4 = cyc;
            repeat (HALF) @(negedge clk);
            if (e <= 10) bits[e-1] = kdata_line;
            dev_clk_low = 1'b0;
        end
        if (stop_after == 0) begin
            repeat (HALF) @(negedge clk);
            dev_data_low = 1'b0;
        end
        ok = 1'b1;
    endtask

    task automatic wait_outcome(input string nm, input int d0, input int e0);
        int n;
        n = 0;
        while (done_cnt == d0 && err_cnt == e0) begin
            n++;
            if (n > 3 * TO) begin bound_fail({nm, "_outcome"}); break; end
            @(negedge clk);
        end
        repeat (20) @(negedge clk);
    endtask

    task automatic do_xfer(input string nm, input logic [7:0] d, input bit nack,
                           input int stop_after, input bit exp_done, input bit exp_err);
        logic [9:0] bits;
        int t4, d0, e0, frames;
        bit ok;
        d0 = done_cnt; e0 = err_cnt;
        start_tx(d);
        chk({nm, "_busy"}, {31'd0, busy}, 32'd1);
        frames = (nack || stop_after != 0) ? NFR : 1;
        for (int f = 0; f < frames; f++) begin
            dev_frame(nack, stop_after, f == 0, bits, t4, ok);
            if (!ok) break;
            if (stop_after == 0) chk({nm, "_bits"}, {22'd0, bits}, {22'd0, frame_model(d)});
        end
        wait_outcome(nm, d0, e0);
        chk({nm, "_done"}, done_cnt - d0, {31'd0, exp_done});
        chk({nm, "_err"}, err_cnt - e0, {31'd0, exp_err});
        if (stop_after != 0) chk({nm, "_timeout_lat"}, err_cyc - t4, FILT + 2 + TO);
        chk({nm, "_lines_released"}, {30'd0, kclk_oe, kdata_oe}, 32'd0);
        chk({nm, "_idle"}, {30'd0, busy, tx_ready}, 32'd1);
    endtask

    typedef struct {
        string      name;
        logic [7:0] data;
        bit         nack;
        int         stop_after;
        bit         exp_done;
        bit         exp_err;
    } vec_t;

    vec_t vecs[5];

    initial begin
        logic [9:0] bits;
        int t4, d0, e0;
        bit ok;
        logic [7:0] rd;
        bit rn;

        vecs[0] = '{"ed_ack",   8'hED, 1'b0, 0, 1'b1, 1'b0};
        vecs[1] = '{"zero_ack", 8'h00, 1'b0, 0, 1'b1, 1'b0};
        vecs[2] = '{"ff_ack",   8'hFF, 1'b0, 0, 1'b1, 1'b0};
        vecs[3] = '{"ed_nack",  8'hED, 1'b1, 0, 1'b0, 1'b1};
        vecs[4] = '{"stall4",   8'h5A, 1'b0, 4, 1'b0, 1'b1};

        repeat (3) @(negedge clk);
        chk("rst_lines", {30'd0, kclk_oe, kdata_oe}, 32'd0);
        chk("rst_pulses", {30'd0, done, err}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_ready_busy", {30'd0, tx_ready, busy}, 32'd2);

        foreach (vecs[i])
            do_xfer(vecs[i].name, vecs[i].data, vecs[i].nack, vecs[i].stop_after,
                    vecs[i].exp_done, vecs[i].exp_err);

        for (int i = 0; i < 6; i++) begin
            rd = 8'($urandom);
            rn = ($urandom_range(0, 3) == 0);
            do_xfer($sformatf("rand%0d", i), rd, rn, 0, !rn, rn);
        end

        // A second offer while busy must not disturb the latched byte.
        d0 = done_cnt; e0 = err_cnt;
        start_tx(8'hA5);
        repeat (3) @(negedge clk);
        chk("busy_ready_low", {30'd0, busy, tx_ready}, 32'd2);
        tx_valid = 1'b1; tx_data = 8'h3C;
        @(negedge clk);
        tx_valid = 1'b0;
        dev_frame(1'b0, 0, 1'b0, bits, t4, ok);
        chk("ignore_bits", {22'd0, bits}, {22'd0, frame_model(8'hA5)});
        wait_outcome("ignore", d0, e0);
        chk("ignore_done", done_cnt - d0, 1);
        chk("ignore_err", err_cnt - e0, 0);

        // Reset during INHIBIT.
        d0 = done_cnt; e0 = err_cnt;
        start_tx(8'h12);
        repeat (5) @(negedge clk);
        chk("inh_oe_before_rst", {31'd0, kclk_oe}, 32'd1);
        rst = 1'b1;
        #1;
        chk("inh_rst_lines", {30'd0, kclk_oe, kdata_oe}, 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("inh_rst_ready", {30'd0, tx_ready, busy}, 32'd2);
        repeat (30) @(negedge clk);
        chk("inh_rst_pulses", (done_cnt - d0) + (err_cnt - e0), 0);

        // Reset mid-SEND.
        d0 = done_cnt; e0 = err_cnt;
        start_tx(8'h34);
        dev_frame(1'b0, 5, 1'b0, bits, t4, ok);
        rst = 1'b1;
        #1;
        chk("send_rst_lines", {30'd0, kclk_oe, kdata_oe}, 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("send_rst_ready", {30'd0, tx_ready, busy}, 32'd2);
        repeat (30) @(negedge clk);
        chk("send_rst_pulses", (done_cnt - d0) + (err_cnt - e0), 0);

        do_xfer("post_rst", 8'hC3, 1'b0, 0, 1'b1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, %0d tests run", n_tests);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/ps2_host_tx.md
PS2_HOST_TX -- requirements
Module: ps2_host_tx

Interface
REQ-001 Parameter INHIBIT_CYCLES, default 10000, SHALL set the clock-inhibit duration in clk cycles (100 us at 100 MHz).
REQ-002 Parameter RTS_CYCLES, default 2000, SHALL set how long data is held low with clock still inhibited before clock release.
REQ-003 Parameter FILTER_CYCLES, default 16, SHALL set the consecutive equal synchronized samples needed to accept a kclk level change.
REQ-004 Parameter TIMEOUT_CYCLES, default 2000000, SHALL set the maximum clk cycles allowed between accepted kclk falling edges.
REQ-005 clk  input  1  system clock; single clock domain.
REQ-006 rst  input  1  asynchronous, active-high reset.
REQ-007 tx_valid  input  1  command byte offered.
REQ-008 tx_data  input  8  command byte, e.g. 0xED or 0xFF.
REQ-009 tx_ready  output  1  high only in IDLE; a transfer starts when tx_valid and tx_ready are both high on a clk edge.
REQ-010 kclk  input  1  PS/2 clock line level, asynchronous.
REQ-011 kdata  input  1  PS/2 data line level, asynchronous.
REQ-012 kclk_oe  output  1  1 = pull clock line low, 0 = release (open drain).
REQ-013 kdata_oe  output  1  1 = pull data line low, 0 = release.
REQ-014 busy  output  1  high in every state except IDLE; the receive path ignores frames while it is high.
REQ-015 done  output  1  one-cycle pulse on a successful, acknowledged transfer.
REQ-016 err  output  1  one-cycle pulse on NACK or timeout.

Function
REQ-017 kclk and kdata SHALL each pass a 2-flop synchronizer; kclk SHALL then go through the FILTER_CYCLES filter; an accepted falling edge is a filtered 1->0 transition.
REQ-018 States: IDLE, INHIBIT, RTS, SEND, WAIT_REL.
REQ-019 IDLE->INHIBIT on handshake: latch tx_data, compute odd parity (parity = ~^tx_data), clear edge index to 0, set kclk_oe=1.
REQ-020 INHIBIT: kclk_oe=1, kdata_oe=0 for exactly INHIBIT_CYCLES cycles, then RTS.
REQ-021 RTS: kclk_oe=1, kdata_oe=1 for RTS_CYCLES cycles, then SEND with kclk_oe=0 and kdata_oe still 1 (start bit).
REQ-022 SEND: on accepted falling edges 1..8, kdata_oe SHALL equal the inverse of data bit 0..7 (LSB first); on edge 9, the inverse of parity; on edge 10, 0 (stop bit).
REQ-023 On edge 11 the synchronized kdata SHALL be sampled: 0 = ACK -> WAIT_REL; 1 = NACK -> error.
REQ-024 WAIT_REL: wait until synchronized kclk and kdata are both 1, then pulse done and enter IDLE.
REQ-025 The timeout counter SHALL clear on every accepted falling edge and on entry to SEND; if it reaches TIMEOUT_CYCLES in SEND or WAIT_REL, the transfer SHALL abort as an error.
REQ-026 Error: release both lines the same cycle, pulse err, then IDLE, unless REQ-031 applies.
REQ-027 tx_valid SHALL be ignored while busy; tx_data SHALL be latched only at the handshake.
REQ-028 kdata_oe and kclk_oe SHALL be registered and glitch-free; data changes only after an accepted falling edge.

Reset
REQ-029 Asserting rst SHALL asynchronously force IDLE with kclk_oe=0, kdata_oe=0, busy=0, done=0, err=0, and tx_ready=1 after release, counters 0, retry count 0.
REQ-030 rst mid-transfer SHALL release both lines immediately and drop the frame with no done or err pulse.

Configuration
REQ-031 With PS2_TX_RETRY_EN defined, an error SHALL restart the transfer at INHIBIT using the latched byte, up to 2 retries; err pulses only after the third failure, and busy stays high throughout.
REQ-032 Without PS2_TX_RETRY_EN, the first error SHALL pulse err and return to IDLE, and no retry logic is instantiated.

Verification
REQ-033 Send 0xED; a device model clocks at 12.5 kHz and ACKs -> data bits 1,0,1,1,0,1,1,1 LSB-first, parity 1, stop released, one done pulse, no err.
REQ-034 Send 0x00 -> parity bit driven 1 (kdata_oe=0 on edge 9); send 0xFF -> parity 0.
REQ-035 The model leaves kdata high on edge 11 (NACK) -> without the macro, err pulse after the frame; with the macro, 3 frames seen and then err.
REQ-036 The model stops clocking after edge 4 -> err exactly TIMEOUT_CYCLES after the 4th edge, both lines released.
REQ-037 Assert rst during INHIBIT and again mid-SEND -> kclk_oe=0 and kdata_oe=0 immediately, tx_ready=1 after release, no done or err.
REQ-038 Pulse tx_valid while busy with a different byte -> ignored; the original byte is transmitted unaltered.
